// File: rtl/aha_tlx_pkg.sv
// Shared definitions for the TLX pulse pacer: FSM encoding and parameter limits.
package aha_tlx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } pacer_state_t;

  localparam int AHA_TLX_MIN_GAP_LIMIT = 2;

endpackage

// File: rtl/aha_tlx_gap_timer.sv
// Load/decrement down-counter that times the spacing interval after each emitted pulse.
module aha_tlx_gap_timer #(
  parameter int  MIN_GAP = 6,
  localparam int W       = $clog2(MIN_GAP)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  output logic [W-1:0] count,
  output logic         done,
  output logic         last
);

  localparam logic [W-1:0] LOAD_VAL = W'(MIN_GAP - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);
  // last lets the FSM leave GAP on the same edge the count reaches zero
  assign last = (count == W'(1));

endmodule

// File: rtl/aha_tlx_pulse_pacer.sv
// Paces single-cycle event strobes into pulses spaced MIN_GAP cycles apart.
// Optional sticky overflow flag: define AHA_TLX_PACER_OVF_EN.
module aha_tlx_pulse_pacer
  import aha_tlx_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MIN_GAP = 6
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             EVENT_IN,
  input  logic             CLR_OVF,
  output logic             PULSE_OUT,
  output logic [CNT_W-1:0] PENDING,
  output logic             BUSY,
  output logic             OVERFLOW
);

  localparam int               GAP_W    = $clog2(MIN_GAP);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  if (MIN_GAP < AHA_TLX_MIN_GAP_LIMIT) begin : g_bad_gap
    $error("aha_tlx_pulse_pacer: MIN_GAP must be at least 2");
  end

  pacer_state_t     state_q;
  pacer_state_t     state_d;
  logic             emit;
  logic             saturated;
  logic             inc;
  logic             ovf_set;
  logic [GAP_W-1:0] gap_count;
  logic             gap_done;
  logic             gap_last;

  aha_tlx_gap_timer #(
    .MIN_GAP (MIN_GAP)
  ) u_gap_timer (
    .clk   (CLK),
    .rst_n (RESETn),
    .load  (emit),
    .count (gap_count),
    .done  (gap_done),
    .last  (gap_last)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PENDING != '0) begin
          emit    = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_last || gap_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // an emit in the same cycle frees a slot, so a saturating event is still accepted
  assign saturated = (PENDING == PEND_MAX);
  assign inc       = EVENT_IN && (!saturated || emit);
  assign ovf_set   = EVENT_IN && saturated && !emit;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      PENDING   <= '0;
      PULSE_OUT <= 1'b0;
    end else begin
      PULSE_OUT <= emit;
      case ({inc, emit})
        2'b10:   PENDING <= PENDING + CNT_W'(1);
        2'b01:   PENDING <= PENDING - CNT_W'(1);
        default: PENDING <= PENDING;
      endcase
    end
  end

  assign BUSY = (PENDING != '0) || (state_q == ST_GAP);

`ifdef AHA_TLX_PACER_OVF_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      OVERFLOW <= 1'b0;
    end else if (ovf_set) begin
      OVERFLOW <= 1'b1;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = CLR_OVF | ovf_set;
  assign OVERFLOW   = 1'b0;
`endif

endmodule

// File: tb/tb_aha_tlx_pulse_pacer.sv
// Scoreboard bench for aha_tlx_pulse_pacer: expected pulse cycles are queued as events are driven.
module tb_aha_tlx_pulse_pacer;

  localparam int CNT_W   = 8;
  localparam int MIN_GAP = 6;

`ifdef AHA_TLX_PACER_OVF_EN
  localparam int EXP_OVF = 1;
`else
  localparam int EXP_OVF = 0;
`endif

  logic             CLK = 1'b0;
  logic             RESETn;
  logic             EVENT_IN;
  logic             CLR_OVF;
  logic             PULSE_OUT;
  logic [CNT_W-1:0] PENDING;
  logic             BUSY;
  logic             OVERFLOW;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int peak     = 0;
  int exp_q[$];
  logic prev_pulse = 1'b0;

  aha_tlx_pulse_pacer #(
    .CNT_W   (CNT_W),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .EVENT_IN  (EVENT_IN),
    .CLR_OVF   (CLR_OVF),
    .PULSE_OUT (PULSE_OUT),
    .PENDING   (PENDING),
    .BUSY      (BUSY),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // pulse monitor: each pulse must match the oldest expected cycle
  always @(negedge CLK) begin
    int exp_c;
    if (PULSE_OUT) begin
      exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("pulse_cycle", cyc, exp_c);
    end
    if (prev_pulse) chk("pulse_back_to_back", int'(PULSE_OUT), 0);
    prev_pulse = PULSE_OUT;
    if (int'(PENDING) > peak) peak = int'(PENDING);
  end

  initial begin
    int t;
    int n_exp;
    RESETn   = 1'b0;
    EVENT_IN = 1'b0;
    CLR_OVF  = 1'b0;
    #3;
    chk("rst_pulse",   int'(PULSE_OUT), 0);
    chk("rst_pending", int'(PENDING),   0);
    chk("rst_busy",    int'(BUSY),      0);
    chk("rst_ovf",     int'(OVERFLOW),  0);
    wait_until(3);
    RESETn = 1'b1;

    // isolated event
    t = cyc + 2;
    wait_until(t);
    EVENT_IN = 1'b1;
    exp_q.push_back(t + 2);
    wait_until(t + 1);
    EVENT_IN = 1'b0;
    chk("single_pend_k1", int'(PENDING), 1);
    chk("single_busy_k1", int'(BUSY), 1);
    wait_until(t + 2);
    chk("single_pend_k2", int'(PENDING), 0);
    chk("single_pulse_k2", int'(PULSE_OUT), 1);
    wait_until(t + 6);
    chk("single_busy_gap", int'(BUSY), 1);
    wait_until(t + 7);
    chk("single_busy_end", int'(BUSY), 0);

    // 5-event burst
    t = cyc + 2;
    peak = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back(t + 2 + MIN_GAP * i);
    for (int i = 0; i < 5; i++) begin
      wait_until(t + i);
      EVENT_IN = 1'b1;
    end
    wait_until(t + 5);
    EVENT_IN = 1'b0;
    wait_until(t + 32);
    chk("burst_peak", peak, 4);
    chk("burst_pend_end", int'(PENDING), 0);
    chk("burst_busy_end", int'(BUSY), 0);

    // second event lands on the emit edge of the first
    t = cyc + 2;
    exp_q.push_back(t + 2);
    exp_q.push_back(t + 8);
    wait_until(t);
    EVENT_IN = 1'b1;
    wait_until(t + 1);
    chk("coinc_pend_k1", int'(PENDING), 1);
    wait_until(t + 2);
    EVENT_IN = 1'b0;
    chk("coinc_pend_k2", int'(PENDING), 1);
    wait_until(t + 14);
    chk("coinc_pend_end", int'(PENDING), 0);
    chk("coinc_busy_end", int'(BUSY), 0);

    // saturation: 300 cycles only reaches 250 at MIN_GAP=6, so hold 311 cycles.
    // Emits occur on edges t+1+6i; 52 of them fall inside the burst.
    t = cyc + 2;
    n_exp = 255 + ((311 - 2) / MIN_GAP + 1);
    for (int k = 0; k < n_exp; k++) exp_q.push_back(t + 2 + MIN_GAP * k);
    wait_until(t);
    EVENT_IN = 1'b1;
    wait_until(t + 309);
    chk("sat_pend", int'(PENDING), 255);
    chk("sat_ovf", int'(OVERFLOW), EXP_OVF);
    wait_until(t + 310);
    CLR_OVF = 1'b1;
    wait_until(t + 311);
    EVENT_IN = 1'b0;
    chk("sat_pend_hold", int'(PENDING), 255);
    chk("ovf_set_wins", int'(OVERFLOW), EXP_OVF);
    wait_until(t + 312);
    CLR_OVF = 1'b0;
    chk("ovf_cleared", int'(OVERFLOW), 0);
    wait_until(t + 2 + MIN_GAP * n_exp + 2);
    chk("sat_pend_end", int'(PENDING), 0);
    chk("sat_busy_end", int'(BUSY), 0);
    chk("sat_pulses_left", exp_q.size(), 0);

    // reset during GAP with 7 pending
    t = cyc + 2;
    exp_q.push_back(t + 2);
    exp_q.push_back(t + 8);
    wait_until(t);
    EVENT_IN = 1'b1;
    wait_until(t + 9);
    EVENT_IN = 1'b0;
    chk("rgap_pend", int'(PENDING), 7);
    chk("rgap_busy", int'(BUSY), 1);
    RESETn = 1'b0;
    #1;
    chk("rgap_pulse_async", int'(PULSE_OUT), 0);
    chk("rgap_pend_async", int'(PENDING), 0);
    chk("rgap_busy_async", int'(BUSY), 0);
    chk("rgap_ovf_async", int'(OVERFLOW), 0);
    wait_until(t + 12);
    RESETn = 1'b1;
    wait_until(t + 40);
    chk("post_rst_pend", int'(PENDING), 0);
    chk("post_rst_busy", int'(BUSY), 0);
    wait_until(t + 41);
    EVENT_IN = 1'b1;
    exp_q.push_back(t + 43);
    wait_until(t + 42);
    EVENT_IN = 1'b0;
    chk("post_rst_new_pend", int'(PENDING), 1);
    wait_until(t + 50);
    chk("post_rst_busy_end", int'(BUSY), 0);
    chk("pulses_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
